// File: rtl/shift_reg_pkg.sv
// Shared constants for the MIDI output gate.
package shift_reg_pkg;
  localparam int MIDI_CH_DEFAULT = 4;
endpackage

// File: rtl/midi_sync_bit.sv
// Single-bit flop synchronizer with asynchronous reset.
module midi_sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic [STAGES-1:0] ff;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ff <= '0;
    end else begin
      ff[0] <= d;
      for (int i = 1; i < STAGES; i++) begin
        ff[i] <= ff[i-1];
      end
    end
  end

  assign q = ff[STAGES-1];
endmodule

// File: rtl/shift_reg.sv
// Per-channel MIDI output gate.
// Optional input synchronizer, registered select mask, registered output.
module shift_reg
  import shift_reg_pkg::*;
#(
  parameter int N_CH        = MIDI_CH_DEFAULT,
  parameter int SYNC_STAGES = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] midi_in,
  input  logic [N_CH-1:0] midi_sel,
  output logic [N_CH-1:0] midi_out
);
  logic [N_CH-1:0] midi_in_s;
  logic [N_CH-1:0] sel_q;

  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign midi_in_s = midi_in;
    end else begin : g_sync
      for (genvar i = 0; i < N_CH; i++) begin : g_ch
        midi_sync_bit #(
          .STAGES(SYNC_STAGES)
        ) u_sync (
          .clk(clk),
          .rst(rst),
          .d  (midi_in[i]),
          .q  (midi_in_s[i])
        );
      end
    end
  endgenerate

  // Output gates on the registered mask, so select takes two edges.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_q    <= '0;
      midi_out <= '0;
    end else begin
      sel_q    <= midi_sel;
      midi_out <= midi_in_s & sel_q;
    end
  end
endmodule

// File: tb/tb_shift_reg.sv
// Self-checking bench for shift_reg (N_CH=4, SYNC_STAGES=0).
module tb_shift_reg;
  import shift_reg_pkg::*;

  logic       clk;
  logic       rst;
  logic [3:0] midi_in;
  logic [3:0] midi_sel;
  logic [3:0] midi_out;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0] din;
    logic [3:0] sel;
    logic [3:0] exp;
  } vec_t;

  vec_t vecs [16];

  shift_reg #(
    .N_CH       (4),
    .SYNC_STAGES(0)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .midi_in (midi_in),
    .midi_sel(midi_sel),
    .midi_out(midi_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [3:0] exp);
    checks++;
    if (midi_out !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, midi_out, exp);
    end
  endtask

  initial begin
    // Each row: drive, one rising edge, then compare.
    // Expected output = din & sel of the previous row.
    vecs[0]  = '{4'h0, 4'h0, 4'h0};
    vecs[1]  = '{4'h1, 4'h0, 4'h0};
    vecs[2]  = '{4'h2, 4'h0, 4'h0};
    vecs[3]  = '{4'hA, 4'hF, 4'h0};
    vecs[4]  = '{4'hA, 4'hF, 4'hA};
    vecs[5]  = '{4'h5, 4'hF, 4'h5};
    vecs[6]  = '{4'hF, 4'h3, 4'hF};
    vecs[7]  = '{4'hF, 4'h3, 4'h3};
    vecs[8]  = '{4'h2, 4'h3, 4'h2};
    vecs[9]  = '{4'hF, 4'h0, 4'h3};
    vecs[10] = '{4'hF, 4'h0, 4'h0};
    vecs[11] = '{4'hF, 4'h8, 4'h0};
    vecs[12] = '{4'hF, 4'h8, 4'h8};
    vecs[13] = '{4'h7, 4'h8, 4'h0};
    vecs[14] = '{4'hF, 4'hF, 4'h8};
    vecs[15] = '{4'hF, 4'hF, 4'hF};

    rst      = 1'b1;
    midi_in  = 4'hF;
    midi_sel = 4'hF;
    #1;
    check("reset_immediate", 4'h0);
    @(posedge clk);
    #1;
    check("reset_held", 4'h0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 16; i++) begin
      midi_in  = vecs[i].din;
      midi_sel = vecs[i].sel;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d", i), vecs[i].exp);
    end

    // Async reset between edges, then recovery with all enabled.
    #2;
    rst = 1'b1;
    #1;
    check("async_reset_no_edge", 4'h0);
    @(negedge clk);
    rst = 1'b0;
    midi_in  = 4'hF;
    midi_sel = 4'hF;
    @(posedge clk);
    #1;
    check("post_reset_edge1", 4'h0);
    @(posedge clk);
    #1;
    check("post_reset_edge2", 4'hF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
